// File: rtl/subtractor_64bit_serial_pkg.sv
// subtractor_64bit_serial_pkg: shared state encoding, slice defaults and sizing helpers
package subtractor_64bit_serial_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int SLICE_DEF = 8;
    localparam int WIDTH_DEF = 64;
    localparam int NUM_SLICES_DEF = WIDTH_DEF / SLICE_DEF;
    function automatic int num_slices(input int width, input int slice);
        return width / slice;
    endfunction
    function automatic bit slice_ok(input int width, input int slice);
        return (width % slice) == 0;
    endfunction
endpackage

// File: rtl/subtractor_64bit_serial_adder.sv
// adder_8bit: one adder slice with carry in/out (a_i/b_i/c_i in, s_o/c_o out)
module adder_8bit
    import subtractor_64bit_serial_pkg::*;
#(
    parameter int W = SLICE_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
endmodule

// File: rtl/subtractor_64bit_serial.sv
// subtractor_64bit_serial: slice-serial Diff = A - B - Bin with valid/ready on both sides; ports clk, reset, in_valid/in_ready/A/B/Bin, out_valid/out_ready/Diff/Bout, busy, and V when SUBTRACTOR_OVERFLOW_FLAG_EN is defined
module subtractor_64bit_serial
    import subtractor_64bit_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy
`ifdef SUBTRACTOR_OVERFLOW_FLAG_EN
   ,output logic             V
`endif
);
    localparam int NS = num_slices(WIDTH, SLICE);
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    if (!slice_ok(WIDTH, SLICE)) begin : g_chk
        $error("WIDTH must be a multiple of SLICE");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d, diff_q, diff_d;
    logic             c_q, c_d, bout_q, bout_d;
    logic [SLICE-1:0] s;
    logic             co, last;

    // Subtraction as A + ~B + ~Bin: the inverted subtrahend is stored so the
    // slice engine is a plain adder.
    adder_8bit #(.W(SLICE)) u_slice (
        .a_i(a_q[cnt_q*SLICE +: SLICE]),
        .b_i(nb_q[cnt_q*SLICE +: SLICE]),
        .c_i(c_q),
        .s_o(s),
        .c_o(co)
    );

    assign last = cnt_q == CW'(NS - 1);

`ifdef SUBTRACTOR_OVERFLOW_FLAG_EN
    logic v_q, v_d;
    // B's sign is the complement of the stored ~B MSB; s[SLICE-1] is Diff's MSB on the last slice.
    assign v_d = (state_q == RUN && last) ?
                 ((a_q[WIDTH-1] == nb_q[WIDTH-1]) & (s[SLICE-1] != a_q[WIDTH-1])) : v_q;
    assign V = v_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        nb_d    = nb_q;
        c_d     = c_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                state_d = RUN;
                a_d     = A;
                nb_d    = ~B;
                c_d     = ~Bin;
                cnt_d   = '0;
            end
        end else if (state_q == RUN) begin
            diff_d[cnt_q*SLICE +: SLICE] = s;
            c_d   = co;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                state_d = DONE;
                bout_d  = ~co;
            end
        end else if (state_q == DONE) begin
            state_d = out_ready ? IDLE : DONE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            nb_q    <= '0;
            c_q     <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_FLAG_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            c_q     <= c_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUBTRACTOR_OVERFLOW_FLAG_EN
            v_q     <= v_d;
`endif
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q == RUN;
    assign out_valid = state_q == DONE;
    assign Diff      = diff_q;
    assign Bout      = bout_q;
endmodule

// File: tb/tb_subtractor_64bit_serial.sv
// tb_subtractor_64bit_serial: directed and random checks of the serial subtractor against plain arithmetic
module tb_subtractor_64bit_serial;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] A = '0, B = '0;
    logic        Bin = 1'b0;
    logic        in_ready, out_valid, Bout, busy;
    logic [63:0] Diff;
`ifdef SUBTRACTOR_OVERFLOW_FLAG_EN
    logic        V;
`endif
    int errors = 0;
    int checks = 0;

    subtractor_64bit_serial dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
        .Diff(Diff), .Bout(Bout), .busy(busy)
`ifdef SUBTRACTOR_OVERFLOW_FLAG_EN
       ,.V(V)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ref_sub(input logic [63:0] a, input logic [63:0] b, input logic bin);
        // bit 64 of the 65-bit difference is the unsigned borrow
        return {1'b0, a} - {1'b0, b} - 65'(bin);
    endfunction

    function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b, input logic bin);
        logic [64:0] s;
        s = {a[63], a} - {b[63], b} - 65'(bin);
        return s[64] != s[63];
    endfunction

    task automatic op(input logic [63:0] a, input logic [63:0] b, input logic bin, input string tag);
        logic [64:0] r;
        int n;
        r = ref_sub(a, b, bin);
        @(negedge clk);
        out_ready = 1'b0;
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd9);
        chk({tag, "_diff"}, Diff, r[63:0]);
        chk({tag, "_bout"}, 64'(Bout), 64'(r[64]));
`ifdef SUBTRACTOR_OVERFLOW_FLAG_EN
        chk({tag, "_v"}, 64'(V), 64'(ref_ovf(a, b, bin)));
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ra, rb, ea[4], eb[4];
        logic        rbin, ebin[4];
        logic [64:0] r;
        int          cyc, last_cyc, oi, ii;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_diff", Diff, 64'd0);
        chk("rst_bout", 64'(Bout), 64'd0);

        op(64'd100, 64'd58, 1'b0, "basic");
        op(64'd0, 64'd1, 1'b0, "borrow_chain");
        op(64'h0000_0001_0000_0000, 64'd0, 1'b1, "borrow_in");
        ra = {$urandom, $urandom};
        op(ra, ra, 1'b0, "equal");
        op(64'h8000_0000_0000_0000, 64'd1, 1'b0, "ovf");
        op(64'd5, 64'd3, 1'b0, "no_ovf");
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rbin = 1'($urandom);
            op(ra, rb, rbin, "rand");
        end

        // reset mid-RUN: leaves a nonzero Diff behind from the earlier ops
        @(negedge clk);
        A = 64'hFFFF_0000_1234_5678; B = 64'd3; Bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_diff", Diff, 64'd0);
        chk("midrst_bout", 64'(Bout), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_idle", 64'(in_ready), 64'd1);
        chk("postrst_busy", 64'(busy), 64'd0);

        // backpressure: hold DONE, poke in_valid, expect nothing to change
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        r = ref_sub(ra, rb, 1'b1);
        A = ra; B = rb; Bin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", 64'(cyc), 64'd9);
        for (int i = 0; i < 5; i++) begin
            A = {$urandom, $urandom}; B = {$urandom, $urandom}; in_valid = 1'b1;
            @(negedge clk);
            chk("bp_diff", Diff, r[63:0]);
            chk("bp_bout", 64'(Bout), 64'(r[64]));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_ov", 64'(out_valid), 64'd0);
        chk("bp_release_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("bp_no_phantom", 64'(busy), 64'd0);

        // back-to-back with out_ready held high
        for (int i = 0; i < 4; i++) begin
            ea[i] = {$urandom, $urandom};
            eb[i] = {$urandom, $urandom};
            ebin[i] = 1'($urandom);
        end
        out_ready = 1'b1;
        oi = 0; ii = 0; cyc = 0; last_cyc = 0;
        while (oi < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                r = ref_sub(ea[oi], eb[oi], ebin[oi]);
                chk("b2b_diff", Diff, r[63:0]);
                chk("b2b_bout", 64'(Bout), 64'(r[64]));
                if (oi > 0) chk("b2b_spacing", 64'(cyc - last_cyc), 64'd10);
                last_cyc = cyc;
                oi++;
            end
            if (in_ready && ii < 4) begin
                A = ea[ii]; B = eb[ii]; Bin = ebin[ii]; in_valid = 1'b1;
                ii++;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("b2b_count", 64'(oi), 64'd4);
        out_ready = 1'b0;
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
